// File: rtl/hwpe_ctrl_reqrsp_arbiter.sv
// Round-robin request arbiter with a PUSH/TRIGGER lock for an HWPE control
// target, plus an in-order route FIFO steering read responses to their issuer.
module hwpe_ctrl_reqrsp_arbiter #(
   parameter int unsigned N_REQ           = 2,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [N_REQ-1:0]                      req_q_valid_i,
   output logic [N_REQ-1:0]                      req_q_ready_o,
   input  logic [N_REQ-1:0]                      req_q_write_i,
   input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      req_q_addr_i,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_q_data_i,
   output logic [N_REQ-1:0]                      req_p_valid_o,
   input  logic [N_REQ-1:0]                      req_p_ready_i,
   output logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_p_data_o,
   output logic                                  tgt_q_valid_o,
   input  logic                                  tgt_q_ready_i,
   output logic                                  tgt_q_write_o,
   output logic [ADDR_WIDTH-1:0]                 tgt_q_addr_o,
   output logic [DATA_WIDTH-1:0]                 tgt_q_data_o,
   input  logic                                  tgt_p_valid_i,
   output logic                                  tgt_p_ready_o,
   input  logic [DATA_WIDTH-1:0]                 tgt_p_data_i,
   output logic [$clog2(N_REQ):0]                lock_owner_o,
   output logic                                  err_o
);

   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CW = PW + 1;

   localparam logic [2:0] IDX_TRIGGER = 3'd0;
   localparam logic [2:0] IDX_SOFTCLR = 3'd3;
   localparam logic [2:0] IDX_PUSH    = 3'd4;

   logic [IW-1:0] r_ptr;
   logic          r_lock;
   logic [IW-1:0] r_owner;
   logic [IW-1:0] r_fifo [MAX_OUTSTANDING];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_cnt;

   logic [N_REQ-1:0] w_elig;
   logic [IW-1:0]    w_cand;
   logic [IW-1:0]    w_gnt;
   logic             w_gnt_vld;
   logic             w_full;
   logic             w_empty;
   logic             w_blocked;
   logic             w_qhs;
   logic             w_push;
   logic             w_pop;
   logic             w_rel;
   logic             w_acq;
   logic [2:0]       w_idx;
   logic [IW-1:0]    w_head;

   assign w_full  = (r_cnt == CW'(MAX_OUTSTANDING));
   assign w_empty = (r_cnt == '0);
   assign w_head  = r_fifo[r_rd];

   always_comb begin
      w_elig = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_elig[i] = req_q_valid_i[i] & (~r_lock | (r_owner == IW'(i)));
      end
   end

   // Scan from the far end so the candidate closest to r_ptr wins last.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_cand    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_cand = IW'((int'(r_ptr) + k) % N_REQ);
         if (w_elig[w_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_cand;
         end
      end
   end

   assign tgt_q_write_o = req_q_write_i[w_gnt];
   assign tgt_q_addr_o  = req_q_addr_i[w_gnt];
   assign tgt_q_data_o  = req_q_data_i[w_gnt];

   assign w_blocked     = ~tgt_q_write_o & w_full;
   assign tgt_q_valid_o = w_gnt_vld & ~w_blocked & ~rst_i;
   assign w_qhs         = tgt_q_valid_o & tgt_q_ready_i;
   assign w_idx         = tgt_q_addr_o[4:2];

   always_comb begin
      req_q_ready_o = '0;
      if (tgt_q_valid_o) begin
         req_q_ready_o[w_gnt] = tgt_q_ready_i;
      end
   end

   assign w_push = w_qhs & ~tgt_q_write_o;
   assign w_rel  = w_qhs & tgt_q_write_o & r_lock & (r_owner == w_gnt)
                 & ((w_idx == IDX_TRIGGER) | (w_idx == IDX_SOFTCLR));
   assign w_acq  = w_qhs & tgt_q_write_o & ~r_lock & (w_idx == IDX_PUSH);

   // Responses with no outstanding read are accepted and dropped.
   always_comb begin
      req_p_valid_o = '0;
      req_p_data_o  = '0;
      tgt_p_ready_o = 1'b1;
      err_o         = 1'b0;
      if (!w_empty) begin
         tgt_p_ready_o         = req_p_ready_i[w_head];
         req_p_valid_o[w_head] = tgt_p_valid_i & ~rst_i;
         req_p_data_o[w_head]  = tgt_p_data_i;
      end else begin
         err_o = tgt_p_valid_i & ~rst_i;
      end
   end

   assign w_pop = tgt_p_valid_i & tgt_p_ready_o & ~w_empty;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr   <= '0;
         r_lock  <= 1'b0;
         r_owner <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_qhs) begin
            r_ptr <= (w_gnt == IW'(N_REQ - 1)) ? '0 : w_gnt + 1'b1;
         end
         if (w_push) begin
            r_fifo[r_wr] <= w_gnt;
            r_wr         <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!w_push && w_pop) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_rel) begin
            r_lock  <= 1'b0;
            r_owner <= '0;
         end else if (w_acq) begin
            r_lock  <= 1'b1;
            r_owner <= w_gnt;
         end
      end
   end

   assign lock_owner_o = {r_lock, r_owner};

endmodule

// File: tb/tb_hwpe_ctrl_reqrsp_arbiter.sv
// Bench for hwpe_ctrl_reqrsp_arbiter: directed scenarios plus random
// traffic, every cycle checked against a queue-based reference model.
module tb_hwpe_ctrl_reqrsp_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int D  = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         q_valid;
   logic [N-1:0]         q_ready;
   logic [N-1:0]         q_write;
   logic [N-1:0][AW-1:0] q_addr;
   logic [N-1:0][DW-1:0] q_data;
   logic [N-1:0]         p_valid;
   logic [N-1:0]         p_ready;
   logic [N-1:0][DW-1:0] p_data;
   logic                 t_q_valid;
   logic                 t_q_ready;
   logic                 t_q_write;
   logic [AW-1:0]        t_q_addr;
   logic [DW-1:0]        t_q_data;
   logic                 t_p_valid;
   logic                 t_p_ready;
   logic [DW-1:0]        t_p_data;
   logic [1:0]           lock_owner;
   logic                 err;

   int n_total = 0;
   int n_bad   = 0;

   int m_ptr;
   bit m_lock;
   int m_owner;
   int m_q[$];

   always #5 clk = ~clk;

   hwpe_ctrl_reqrsp_arbiter #(
      .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(D)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .req_q_valid_i(q_valid),
      .req_q_ready_o(q_ready),
      .req_q_write_i(q_write),
      .req_q_addr_i(q_addr),
      .req_q_data_i(q_data),
      .req_p_valid_o(p_valid),
      .req_p_ready_i(p_ready),
      .req_p_data_o(p_data),
      .tgt_q_valid_o(t_q_valid),
      .tgt_q_ready_i(t_q_ready),
      .tgt_q_write_o(t_q_write),
      .tgt_q_addr_o(t_q_addr),
      .tgt_q_data_o(t_q_data),
      .tgt_p_valid_i(t_p_valid),
      .tgt_p_ready_o(t_p_ready),
      .tgt_p_data_i(t_p_data),
      .lock_owner_o(lock_owner),
      .err_o(err)
   );

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drv(int r, bit v, bit w, int idx);
      q_valid[r] = v;
      q_write[r] = w;
      q_addr[r]  = (AW'(r) << 8) | (AW'(idx) << 2);
      q_data[r]  = {$urandom, $urandom};
   endtask

   task automatic step();
      int g;
      int h;
      bit gv;
      bit ev;
      bit hs;
      bit pop;
      logic [N-1:0]         e_rdy;
      logic [N-1:0]         e_pv;
      logic [N-1:0][DW-1:0] e_pd;
      @(negedge clk);
      gv = 0;
      g  = 0;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (!gv && q_valid[i] && (!m_lock || m_owner == i)) begin
            gv = 1;
            g  = i;
         end
      end
      ev = gv && !rst && !(!q_write[g] && m_q.size() == D);
      check("tq_valid", t_q_valid, ev);
      e_rdy = '0;
      if (ev) e_rdy[g] = t_q_ready;
      check("q_ready", q_ready, e_rdy);
      if (ev) begin
         check("tq_write", t_q_write, q_write[g]);
         check("tq_addr", t_q_addr, q_addr[g]);
         check("tq_data", t_q_data, q_data[g]);
      end
      e_pv = '0;
      e_pd = '0;
      if (rst) begin
         check("p_valid_rst", p_valid, e_pv);
         check("err_rst", err, 1'b0);
      end else if (m_q.size() > 0) begin
         h = m_q[0];
         e_pv[h] = t_p_valid;
         e_pd[h] = t_p_data;
         check("p_valid", p_valid, e_pv);
         check("p_data", p_data, e_pd);
         check("tp_ready", t_p_ready, p_ready[h]);
         check("err", err, 1'b0);
      end else begin
         check("p_valid", p_valid, e_pv);
         check("p_data", p_data, e_pd);
         check("tp_ready", t_p_ready, 1'b1);
         check("err", err, t_p_valid);
      end
      check("lock", lock_owner, {m_lock, 1'(m_owner)});
      hs  = ev && t_q_ready;
      pop = !rst && m_q.size() > 0 && t_p_valid && p_ready[m_q[0]];
      @(posedge clk);
      if (rst) begin
         m_ptr = 0; m_lock = 0; m_owner = 0; m_q.delete();
      end else begin
         if (pop) void'(m_q.pop_front());
         if (hs) begin
            int idx;
            idx   = int'(q_addr[g][4:2]);
            m_ptr = (g + 1) % N;
            if (!q_write[g]) begin
               m_q.push_back(g);
            end else if (m_lock && m_owner == g && (idx == 0 || idx == 3)) begin
               m_lock = 0; m_owner = 0;
            end else if (!m_lock && idx == 4) begin
               m_lock = 1; m_owner = g;
            end
         end
      end
      #1;
   endtask

   task automatic idle();
      q_valid = '0;
      t_p_valid = 1'b0;
   endtask

   initial begin
      m_ptr = 0; m_lock = 0; m_owner = 0;
      rst = 1'b1;
      q_valid = '0; q_write = '0; q_addr = '0; q_data = '0;
      p_ready = '1; t_q_ready = 1'b1; t_p_valid = 1'b0; t_p_data = '0;
      @(posedge clk); #1;
      step();
      step();
      rst = 1'b0;
      check("rst_lock", lock_owner, 2'b00);
      check("rst_err", err, 1'b0);

      // back-to-back reads from both requesters, then in-order responses
      drv(0, 1, 0, 1); drv(1, 1, 0, 1);
      repeat (4) step();
      q_valid = '0;
      t_p_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         t_p_data = {$urandom, $urandom};
         step();
      end
      idle();
      step();

      // lock by requester 1, requester 0 locked out until TRIGGER
      drv(1, 1, 1, 4);
      step();
      q_valid = '0;
      check("lock_acq", lock_owner, 2'b11);
      drv(0, 1, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drv(1, 1, 1, 4);
         step();
         check("lockout", q_ready[0], 1'b0);
      end
      drv(1, 1, 1, 0);
      step();
      check("lock_rel", lock_owner, 2'b00);
      q_valid[1] = 1'b0;
      step();
      idle();
      t_p_valid = 1'b1;
      step();
      idle();

      // fill the route FIFO, stall a read, let a write through, then pop
      drv(0, 1, 0, 2);
      repeat (4) step();
      step();
      drv(0, 1, 1, 6);
      step();
      drv(0, 1, 0, 2);
      t_p_valid = 1'b1;
      step();
      t_p_valid = 1'b0;
      step();
      q_valid = '0;
      t_p_valid = 1'b1;
      repeat (4) step();

      // stray response with an empty FIFO
      step();
      check("stray_err", err, 1'b1);
      idle();
      step();
      check("err_pulse", err, 1'b0);

      // response backpressure
      drv(0, 1, 0, 1);
      step();
      q_valid = '0;
      t_p_valid = 1'b1;
      t_p_data = 64'hdead_beef_0123_4567;
      p_ready[0] = 1'b0;
      repeat (3) step();
      p_ready[0] = 1'b1;
      step();
      idle();
      step();

      // reset with reads outstanding and the lock held
      drv(1, 1, 1, 4);
      step();
      drv(1, 1, 0, 1);
      repeat (2) step();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("post_rst_lock", lock_owner, 2'b00);
      t_p_valid = 1'b1;
      step();
      check("late_err", err, 1'b1);
      idle();
      step();

      for (int c = 0; c < 3000; c++) begin
         for (int r = 0; r < N; r++) begin
            drv(r, ($urandom % 4) != 0, ($urandom % 3) == 0, int'($urandom % 8));
            p_ready[r] = ($urandom % 4) != 0;
         end
         t_q_ready = ($urandom % 4) != 0;
         t_p_valid = ($urandom % 2) != 0;
         t_p_data  = {$urandom, $urandom};
         rst       = ($urandom % 200) == 0;
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
